// File: rtl/conv_pkg.sv
// Shared types for the convolution input-buffer controller.
// Holds the FSM state encoding and the counter-width helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } conv_ctrl_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_pos_cnt.sv
// Row/column position counter for the pixel stream.
// Decodes window completion and the stride phase on both axes.
module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter int img_width  = 28,
  parameter int img_height = 28,
  parameter int kernel_dim = 3,
  parameter int stride     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         adv,
  output logic [cnt_w(img_height)-1:0] row,
  output logic [cnt_w(img_width)-1:0]  col,
  output logic                         hit,
  output logic                         last
);

  localparam int RW = cnt_w(img_height);
  localparam int CW = cnt_w(img_width);
  localparam int PW = cnt_w(stride);

  localparam logic [RW-1:0] ROW_MAX = RW'(img_height - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_K   = RW'(kernel_dim - 1);
  localparam logic [CW-1:0] COL_K   = CW'(kernel_dim - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(stride - 1);

  // Phases hold (pos - kernel_dim + 1) % stride once pos >= kernel_dim-1.
  logic [PW-1:0] rph;
  logic [PW-1:0] cph;
  logic          col_wrap;

  assign col_wrap = (col == COL_MAX);
  assign last     = (row == ROW_MAX) && col_wrap;
  assign hit      = (row >= ROW_K) && (col >= COL_K) &&
                    (rph == '0) && (cph == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
      rph <= '0;
      cph <= '0;
    end else if (adv) begin
      if (col_wrap) begin
        col <= '0;
        cph <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
        if ((row == ROW_MAX) || (row < ROW_K))
          rph <= '0;
        else
          rph <= (rph == PH_MAX) ? '0 : rph + PW'(1);
      end else begin
        col <= col + CW'(1);
        if (col < COL_K)
          cph <= '0;
        else
          cph <= (cph == PH_MAX) ? '0 : cph + PW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_ibuf_ctrl.sv
// Frame sequencer for the conv_ibuf sliding-window line buffer.
// Define CONV_IBUF_CTRL_PERF_EN to add source/sink stall counters.
module conv_ibuf_ctrl
  import conv_pkg::*;
#(
  parameter int img_width  = 28,
  parameter int img_height = 28,
  parameter int kernel_dim = 3,
  parameter int stride     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic                         o_ibuf_we,
  output logic                         o_win_valid,
  input  logic                         i_win_ready,
  output logic [cnt_w(img_height)-1:0] o_win_row,
  output logic [cnt_w(img_width)-1:0]  o_win_col,
  output logic                         o_busy,
  output logic                         o_done
`ifdef CONV_IBUF_CTRL_PERF_EN
  ,
  output logic [31:0]                  o_sink_stall,
  output logic [31:0]                  o_src_stall
`endif
);

  localparam int RW = cnt_w(img_height);
  localparam int CW = cnt_w(img_width);

  localparam logic [RW-1:0] ROW_K = RW'(kernel_dim - 1);
  localparam logic [CW-1:0] COL_K = CW'(kernel_dim - 1);

  conv_ctrl_state_t state;
  conv_ctrl_state_t nstate;

  logic          clr;
  logic          accept;
  logic          hit;
  logic          last;
  logic          win_last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  assign o_ready     = (state == LOAD);
  assign o_win_valid = (state == WAIT);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);
  assign accept      = i_valid & o_ready;
  assign o_ibuf_we   = accept;

  conv_pos_cnt #(
    .img_width  (img_width),
    .img_height (img_height),
    .kernel_dim (kernel_dim),
    .stride     (stride)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .adv  (accept),
    .row  (row),
    .col  (col),
    .hit  (hit),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_win_row <= '0;
      o_win_col <= '0;
      win_last  <= 1'b0;
    end else begin
      state <= nstate;
      if (accept && hit) begin
        o_win_row <= row - ROW_K;
        o_win_col <= col - COL_K;
        win_last  <= last;
      end
    end
  end

  always_comb begin
    nstate = state;
    clr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          nstate = LOAD;
          clr    = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (hit)
            nstate = WAIT;
          else if (last)
            nstate = DONE;
        end
      end
      WAIT: begin
        if (i_win_ready)
          nstate = win_last ? DONE : LOAD;
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

`ifdef CONV_IBUF_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || ((state == IDLE) && i_start)) begin
      o_sink_stall <= '0;
      o_src_stall  <= '0;
    end else begin
      if ((state == WAIT) && !i_win_ready && (o_sink_stall != '1))
        o_sink_stall <= o_sink_stall + 32'd1;
      if ((state == LOAD) && !i_valid && (o_src_stall != '1))
        o_src_stall <= o_src_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_ibuf_ctrl.sv
// Bench for conv_ibuf_ctrl: 4x4/s1 and 5x5/s2 instances vs a pixel-index model.
// Honours CONV_IBUF_CTRL_PERF_EN for the stall counters.
module tb_conv_ibuf_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, i_valid, i_win_ready;
  int   sel;
  logic st0, st1;
  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);

  logic       rdy0, we0, wv0, busy0, done0;
  logic [1:0] wr0, wc0;
  logic       rdy1, we1, wv1, busy1, done1;
  logic [2:0] wr1, wc1;
`ifdef CONV_IBUF_CTRL_PERF_EN
  logic [31:0] ss0, sr0, ss1, sr1;
`endif

  conv_ibuf_ctrl #(
    .img_width(4), .img_height(4), .kernel_dim(3), .stride(1)
  ) dut0 (
    .clk(clk), .rst(rst), .i_start(st0), .i_valid(i_valid),
    .o_ready(rdy0), .o_ibuf_we(we0), .o_win_valid(wv0),
    .i_win_ready(i_win_ready), .o_win_row(wr0), .o_win_col(wc0),
    .o_busy(busy0), .o_done(done0)
`ifdef CONV_IBUF_CTRL_PERF_EN
    , .o_sink_stall(ss0), .o_src_stall(sr0)
`endif
  );

  conv_ibuf_ctrl #(
    .img_width(5), .img_height(5), .kernel_dim(3), .stride(2)
  ) dut1 (
    .clk(clk), .rst(rst), .i_start(st1), .i_valid(i_valid),
    .o_ready(rdy1), .o_ibuf_we(we1), .o_win_valid(wv1),
    .i_win_ready(i_win_ready), .o_win_row(wr1), .o_win_col(wc1),
    .o_busy(busy1), .o_done(done1)
`ifdef CONV_IBUF_CTRL_PERF_EN
    , .o_sink_stall(ss1), .o_src_stall(sr1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: frame = pixel index stream; windows from row/col arithmetic.
  localparam int K = 3;
  int      mw = 4, mh = 4, ms = 1;
  bit      m_active, m_pend, m_done;
  int      m_p, m_wr, m_wc;
  longint  m_ss, m_sr;
  int      m_log[$];

  function automatic bit is_win(input int r, input int c);
    return (r >= K - 1) && (c >= K - 1) &&
           ((r - K + 1) % ms == 0) && ((c - K + 1) % ms == 0);
  endfunction

  function automatic bit m_ready();
    return m_active && !m_pend && !m_done && (m_p < mw * mh);
  endfunction

  always @(posedge clk) begin
    bit rdy;
    int r, c;
    rdy = m_ready();
    if (rst) begin
      m_active = 0; m_pend = 0; m_done = 0;
      m_p = 0; m_wr = 0; m_wc = 0; m_ss = 0; m_sr = 0;
    end else begin
      if (m_pend && !i_win_ready) m_ss++;
      if (rdy && !i_valid) m_sr++;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_p = 0; m_ss = 0; m_sr = 0;
        end
      end else if (m_done) begin
        m_done = 0; m_active = 0;
      end else if (m_pend) begin
        if (i_win_ready) begin
          m_pend = 0;
          if (m_p == mw * mh) m_done = 1;
        end
      end else if (i_valid) begin
        r = m_p / mw;
        c = m_p % mw;
        m_p++;
        if (is_win(r, c)) begin
          m_pend = 1;
          m_wr = r - K + 1;
          m_wc = c - K + 1;
          m_log.push_back(m_wr * 16 + m_wc);
        end else if (m_p == mw * mh) begin
          m_done = 1;
        end
      end
    end
  end

  bit chk_en = 0;
  int cyc = 0, n_we = 0, n_done = 0, t11 = -1, t_wv = -1;
  int dut_log[$];

  always @(negedge clk) begin
    logic g_rdy, g_we, g_wv, g_busy, g_done;
    int   g_wr, g_wc;
    cyc++;
    g_rdy  = sel ? rdy1 : rdy0;
    g_we   = sel ? we1 : we0;
    g_wv   = sel ? wv1 : wv0;
    g_busy = sel ? busy1 : busy0;
    g_done = sel ? done1 : done0;
    g_wr   = sel ? int'(wr1) : int'(wr0);
    g_wc   = sel ? int'(wc1) : int'(wc0);
    if (chk_en) begin
      chk("ready", g_rdy, m_ready());
      chk("ibuf_we", g_we, i_valid & m_ready());
      chk("win_valid", g_wv, m_pend);
      chk("busy", g_busy, m_active);
      chk("done", g_done, m_done);
      chk("win_row", g_wr, m_wr);
      chk("win_col", g_wc, m_wc);
`ifdef CONV_IBUF_CTRL_PERF_EN
      chk("sink_stall", sel ? ss1 : ss0, m_ss);
      chk("src_stall", sel ? sr1 : sr0, m_sr);
`endif
      if (g_wv === 1'b1 && i_win_ready) dut_log.push_back(g_wr * 16 + g_wc);
      if (g_we === 1'b1) begin
        n_we++;
        if (n_we == 11) t11 = cyc;
      end
      if (g_wv === 1'b1 && t_wv < 0) t_wv = cyc;
      if (g_done === 1'b1) n_done++;
    end
  end

  task automatic clear_logs();
    dut_log.delete();
    m_log.delete();
    n_we = 0; n_done = 0; t11 = -1; t_wv = -1;
  endtask

  task automatic do_reset(input int s);
    rst = 1; start = 0; i_valid = 0; i_win_ready = 0;
    @(posedge clk); #1;
    sel = s;
    mw = s ? 5 : 4; mh = mw; ms = s ? 2 : 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic frame(input int vp, input int rp, input bit stall5,
                       input bit alt, input bit glitch, input int rst_at);
    int  stalls = 0;
    int  budget = 0;
    bit  tog = 0;
    clear_logs();
    start = 1; i_valid = 0; i_win_ready = 0;
    @(posedge clk); #1;
    start = 0;
    while (m_active) begin
      if (rst_at >= 0 && m_p == rst_at) begin
        rst = 1; i_valid = 0; i_win_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      if (alt) begin
        i_valid = tog; tog = !tog;
      end else begin
        i_valid = ($urandom % 100) < vp;
      end
      if (stall5 && m_pend && stalls < 5) begin
        i_win_ready = 0; stalls++;
      end else begin
        i_win_ready = ($urandom % 100) < rp;
      end
      start = glitch && ($urandom % 3 == 0);
      @(posedge clk); #1;
      budget++;
      if (budget > 3000) begin
        chk("frame_timeout", budget, 0);
        break;
      end
    end
    start = 0; i_valid = 0; i_win_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string nm, input int e0, input int e1,
                         input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_n"}, dut_log.size(), 4);
    chk({nm, "_model_n"}, m_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_log.size()) chk({nm, "_win"}, dut_log[i], e[i]);
      if (i < m_log.size()) chk({nm, "_model_win"}, m_log[i], e[i]);
    end
  endtask

  initial begin
    rst = 1; start = 0; i_valid = 0; i_win_ready = 0; sel = 0;
    @(posedge clk); #1;
    chk_en = 1;
    do_reset(0);

    frame(100, 100, 0, 0, 0, -1);
    chk_log("s4x4", 0, 1, 16, 17);
    chk("s4x4_writes", n_we, 16);
    chk("s4x4_wv_after_11th", t_wv - t11, 1);
    chk("s4x4_done", n_done, 1);

    do_reset(1);
    frame(100, 100, 0, 0, 0, -1);
    chk_log("s5x5", 0, 2, 32, 34);
    chk("s5x5_writes", n_we, 25);
    chk("s5x5_done", n_done, 1);

    do_reset(0);
    frame(100, 100, 1, 0, 0, -1);
    chk_log("bp", 0, 1, 16, 17);
`ifdef CONV_IBUF_CTRL_PERF_EN
    chk("bp_sink_stall", ss0, 5);
`endif

    frame(0, 100, 0, 1, 0, -1);
    chk_log("gaps", 0, 1, 16, 17);
    chk("gaps_writes", n_we, 16);

    frame(100, 100, 0, 0, 0, 7);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", rdy0, 0);
    frame(100, 100, 0, 0, 0, -1);
    chk_log("after_rst", 0, 1, 16, 17);
    chk("after_rst_done", n_done, 1);

    frame(70, 60, 0, 0, 1, -1);
    chk_log("glitch4", 0, 1, 16, 17);
    chk("glitch4_done", n_done, 1);

    do_reset(1);
    frame(60, 50, 0, 0, 1, -1);
    chk_log("glitch5", 0, 2, 32, 34);
    chk("glitch5_done", n_done, 1);

    for (int i = 0; i < 6; i++) begin
      do_reset(i % 2);
      frame(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
            0, 0, 1, -1);
      chk("rand_writes", n_we, (i % 2) ? 25 : 16);
      chk("rand_done", n_done, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
